// File: rtl/wrr4_pkg.sv
// Shared types for the 4-input weighted round-robin packet arbiter.
package wrr4_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  typedef logic [1:0] src_idx_t;

  function automatic src_idx_t rot_idx(input src_idx_t base, input src_idx_t off);
    return base + off;
  endfunction

endpackage

// File: rtl/wrr4_pick.sv
// Rotating-priority picker: first input at or after cur+1 (wrapping to cur) that is
// valid and has a non-zero weight.
module wrr4_pick
  import wrr4_pkg::*;
(
  input  logic [3:0] valid,
  input  logic [3:0] nz,
  input  logic [1:0] cur,
  output logic       found,
  output logic [1:0] idx
);

  src_idx_t cand;

  // Walk from lowest priority (cur) to highest (cur+1) so the last hit wins.
  always_comb begin
    found = 1'b0;
    idx   = cur;
    cand  = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = rot_idx(cur, 2'(k));
      if (valid[cand] && nz[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr4_arb.sv
// 4-input AXI-Stream packet arbiter, weighted round-robin: each input may send up to
// wN whole packets per turn before the grant moves on. Output stage is registered.
module wrr4_arb
  import wrr4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter bit          TLAST_ARB    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s0_TDATA,
  input  logic                    s0_TVALID,
  input  logic                    s0_TLAST,
  output logic                    s0_TREADY,
  input  logic [DATA_WIDTH-1:0]   s1_TDATA,
  input  logic                    s1_TVALID,
  input  logic                    s1_TLAST,
  output logic                    s1_TREADY,
  input  logic [DATA_WIDTH-1:0]   s2_TDATA,
  input  logic                    s2_TVALID,
  input  logic                    s2_TLAST,
  output logic                    s2_TREADY,
  input  logic [DATA_WIDTH-1:0]   s3_TDATA,
  input  logic                    s3_TVALID,
  input  logic                    s3_TLAST,
  output logic                    s3_TREADY,
  input  logic [WEIGHT_WIDTH-1:0] w0,
  input  logic [WEIGHT_WIDTH-1:0] w1,
  input  logic [WEIGHT_WIDTH-1:0] w2,
  input  logic [WEIGHT_WIDTH-1:0] w3,
  output logic [DATA_WIDTH-1:0]   o_TDATA,
  output logic                    o_TVALID,
  output logic                    o_TLAST,
  output logic [1:0]              o_src,
  input  logic                    o_TREADY,
  output logic                    busy
);

  localparam logic [WEIGHT_WIDTH-1:0] CreditOne = WEIGHT_WIDTH'(1);

  state_e                  state_q, state_d;
  src_idx_t                cur_q, cur_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [DATA_WIDTH-1:0]   o_tdata_q, o_tdata_d;
  logic                    o_tvalid_q, o_tvalid_d;
  logic                    o_tlast_q, o_tlast_d;
  src_idx_t                o_src_q, o_src_d;

  logic [DATA_WIDTH-1:0]   s_data [4];
  logic [WEIGHT_WIDTH-1:0] w [4];
  logic [3:0]              s_valid, s_last, nz;
  logic                    load, grant, flit;
  logic                    pick_found;
  src_idx_t                pick_idx;

  assign s_data  = '{s0_TDATA, s1_TDATA, s2_TDATA, s3_TDATA};
  assign w       = '{w0, w1, w2, w3};
  assign s_valid = {s3_TVALID, s2_TVALID, s1_TVALID, s0_TVALID};
  assign s_last  = {s3_TLAST, s2_TLAST, s1_TLAST, s0_TLAST};
  assign nz      = {w3 != '0, w2 != '0, w1 != '0, w0 != '0};

  // TREADY is gated by output-register space, so a flit can never be lost.
  assign load  = !o_tvalid_q || o_TREADY;
  assign grant = (state_q == StLocked) && load;
  assign flit  = grant && s_valid[cur_q];

  assign s0_TREADY = grant && (cur_q == 2'd0);
  assign s1_TREADY = grant && (cur_q == 2'd1);
  assign s2_TREADY = grant && (cur_q == 2'd2);
  assign s3_TREADY = grant && (cur_q == 2'd3);

  wrr4_pick u_pick (
    .valid (s_valid),
    .nz    (nz),
    .cur   (cur_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    credit_d   = credit_q;
    o_tdata_d  = o_tdata_q;
    o_tvalid_d = o_tvalid_q;
    o_tlast_d  = o_tlast_q;
    o_src_d    = o_src_q;

    unique case (state_q)
      StIdle: begin
        if (s_valid[cur_q] && (credit_q != '0) && nz[cur_q]) begin
          state_d = StLocked;
        end else if (pick_found) begin
          cur_d    = pick_idx;
          credit_d = w[pick_idx];
          state_d  = StLocked;
        end
      end
      StLocked: begin
        if (flit && (s_last[cur_q] || !TLAST_ARB)) begin
          credit_d = credit_q - CreditOne;
          state_d  = StIdle;
        end
      end
    endcase

    if (load) begin
      o_tvalid_d = flit;
      if (flit) begin
        o_tdata_d = s_data[cur_q];
        o_tlast_d = s_last[cur_q];
        o_src_d   = cur_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_q      <= 2'd3;
      credit_q   <= '0;
      o_tdata_q  <= '0;
      o_tvalid_q <= 1'b0;
      o_tlast_q  <= 1'b0;
      o_src_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      credit_q   <= credit_d;
      o_tdata_q  <= o_tdata_d;
      o_tvalid_q <= o_tvalid_d;
      o_tlast_q  <= o_tlast_d;
      o_src_q    <= o_src_d;
    end
  end

  assign o_TDATA  = o_tdata_q;
  assign o_TVALID = o_tvalid_q;
  assign o_TLAST  = o_tlast_q;
  assign o_src    = o_src_q;
  assign busy     = (state_q == StLocked);

endmodule
